// File: rtl/diad_stage_iaif.sv
// Fetch front end of the diad pipeline: owns the fetch PC, tracks in-flight imem requests and buffers returned instructions for ID.
// Optional bubble counter port ow_perf_bubble is compiled in when DIAD_IAIF_PERF_EN is defined.
module diad_stage_iaif #(
  parameter int ADDR_WIDTH = 24,
  parameter int INSTR_WIDTH = 24,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  output logic                   ow_imem_req,
  output logic [ADDR_WIDTH-1:0]  ow_imem_addr,
  input  logic                   iw_imem_gnt,
  input  logic                   iw_imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] iw_imem_rdata,
  input  logic                   iw_redirect,
  input  logic [ADDR_WIDTH-1:0]  iw_redirect_pc,
  output logic                   ow_ifid_valid,
  output logic [INSTR_WIDTH-1:0] ow_ifid_instr,
  output logic [ADDR_WIDTH-1:0]  ow_ifid_pc,
  input  logic                   iw_ifid_ready
`ifdef DIAD_IAIF_PERF_EN
  , output logic [31:0]          ow_perf_bubble
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_tag [DEPTH];
  logic [PW-1:0]          r_tag_wr;
  logic [PW-1:0]          r_tag_rd;
  logic [CW-1:0]          r_outstanding;
  logic [CW-1:0]          r_discard;
  logic [ADDR_WIDTH-1:0]  r_buf_pc [DEPTH];
  logic [INSTR_WIDTH-1:0] r_buf_instr [DEPTH];
  logic [PW-1:0]          r_buf_wr;
  logic [PW-1:0]          r_buf_rd;
  logic [CW-1:0]          r_buf_count;

  logic req_fire;
  logic rsp_take;
  logic rsp_keep;
  logic ifid_pop;

  // req is gated by reset so it reads low while the block is held in reset
  assign ow_imem_req  = iw_rst && !iw_redirect &&
                        (({1'b0, r_buf_count} + {1'b0, r_outstanding}) < DEPTH_W);
  assign ow_imem_addr = r_pc;
  assign req_fire     = ow_imem_req && iw_imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp_take = iw_imem_rvalid && (r_outstanding != '0);
  assign rsp_keep = rsp_take && (r_discard == '0) && !iw_redirect;

  assign ow_ifid_valid = (r_buf_count != '0);
  assign ow_ifid_instr = r_buf_instr[r_buf_rd];
  assign ow_ifid_pc    = r_buf_pc[r_buf_rd];
  assign ifid_pop      = ow_ifid_valid && iw_ifid_ready && !iw_redirect;

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_pc          <= RESET_PC;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
      r_buf_count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]       <= '0;
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
    end else begin
      if (iw_redirect)   r_pc <= iw_redirect_pc;
      else if (req_fire) r_pc <= r_pc + ADDR_WIDTH'(1);

      if (req_fire) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= r_tag_wr + PW'(1);
      end
      if (rsp_take) r_tag_rd <= r_tag_rd + PW'(1);
      r_outstanding <= r_outstanding + CW'(req_fire) - CW'(rsp_take);

      // Every request still in flight after a redirect is stale, including any
      // already marked for discard, so the new count is just what remains.
      if (iw_redirect)
        r_discard <= r_outstanding - CW'(rsp_take);
      else if (rsp_take && (r_discard != '0))
        r_discard <= r_discard - CW'(1);

      if (iw_redirect) begin
        r_buf_wr    <= '0;
        r_buf_rd    <= '0;
        r_buf_count <= '0;
      end else begin
        if (rsp_keep) begin
          r_buf_pc[r_buf_wr]    <= r_tag[r_tag_rd];
          r_buf_instr[r_buf_wr] <= iw_imem_rdata;
          r_buf_wr              <= r_buf_wr + PW'(1);
        end
        if (ifid_pop) r_buf_rd <= r_buf_rd + PW'(1);
        r_buf_count <= r_buf_count + CW'(rsp_keep) - CW'(ifid_pop);
      end
    end
  end

`ifdef DIAD_IAIF_PERF_EN
  logic [31:0] r_perf_bubble;

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst)
      r_perf_bubble <= '0;
    else if (!ow_ifid_valid && iw_ifid_ready && (r_perf_bubble != '1))
      r_perf_bubble <= r_perf_bubble + 32'd1;
  end

  assign ow_perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_diad_stage_iaif.sv
// Bench for diad_stage_iaif: in-order memory model with configurable latency plus a fetch scoreboard.
module tb_diad_stage_iaif;
  localparam int AW = 24;
  localparam int IW = 24;
  localparam int DEPTH = 4;

  logic r_clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req;
  logic [AW-1:0] imem_addr;
  logic imem_gnt = 1'b0;
  logic imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic ifid_valid;
  logic [IW-1:0] ifid_instr;
  logic [AW-1:0] ifid_pc;
  logic ifid_ready = 1'b0;
`ifdef DIAD_IAIF_PERF_EN
  logic [31:0] perf_bubble;
`endif

  diad_stage_iaif #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .iw_clk(r_clk),
    .iw_rst(rst_n),
    .ow_imem_req(imem_req),
    .ow_imem_addr(imem_addr),
    .iw_imem_gnt(imem_gnt),
    .iw_imem_rvalid(imem_rvalid),
    .iw_imem_rdata(imem_rdata),
    .iw_redirect(redirect),
    .iw_redirect_pc(redirect_pc),
    .ow_ifid_valid(ifid_valid),
    .ow_ifid_instr(ifid_instr),
    .ow_ifid_pc(ifid_pc),
    .iw_ifid_ready(ifid_ready)
`ifdef DIAD_IAIF_PERF_EN
    , .ow_perf_bubble(perf_bubble)
`endif
  );

  always #5 r_clk = ~r_clk;

  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] instr; } exp_t;
  typedef struct { logic [AW-1:0] addr; int due; } mem_t;
  typedef struct { logic gnt; logic rdy; logic req; logic [AW-1:0] addr; logic valid; logic [AW-1:0] pc; } vec_t;

  exp_t sb[$];
  mem_t memq[$];
  int cyc, lat, last_due, n_grants, n_pass, n_total;
  logic [AW-1:0] exp_pc;
  logic gnt_en, rdy_en, redir_en;
  logic [AW-1:0] redir_tgt;
  logic popped_v;
  logic [AW-1:0] popped_pc;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return a ^ 24'hC3A55A ^ {a[11:0], a[23:12]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    imem_gnt = gnt_en;
    ifid_ready = rdy_en;
    redirect = redir_en;
    redirect_pc = redir_tgt;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = instr_of(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = '0;
    end
    #1;
  endtask

  task automatic sample();
    exp_t e;
    int d;
    popped_v = 1'b0;
    if (imem_rvalid) void'(memq.pop_front());
    if (imem_req && imem_gnt) begin
      chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      memq.push_back('{addr: imem_addr, due: d});
      last_due = d;
      sb.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
      exp_pc = exp_pc + 1'b1;
      n_grants++;
    end
    if (redirect) begin
      chk("req_during_redirect", 32'(imem_req), 32'(0));
      sb.delete();
      exp_pc = redirect_pc;
    end else if (ifid_valid && ifid_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: popped pc 0x%0h with nothing expected (cycle %0d)", ifid_pc, cyc);
      end else begin
        e = sb.pop_front();
        chk("ifid_pc", 32'(ifid_pc), 32'(e.pc));
        chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
      end
      popped_v = 1'b1;
      popped_pc = ifid_pc;
    end
  endtask

  task automatic advance();
    @(posedge r_clk);
    @(negedge r_clk);
    cyc++;
  endtask

  task automatic step();
    drive();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gnt_en = 1'b0; rdy_en = 1'b0; redir_en = 1'b0; redir_tgt = '0;
    imem_gnt = 1'b0; ifid_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    memq.delete(); sb.delete();
    exp_pc = '0; last_due = -1; n_grants = 0; lat = 1;
    @(negedge r_clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'(0));
    chk("rst_valid", 32'(ifid_valid), 32'(0));
    chk("rst_pc", 32'(ifid_pc), 32'(0));
    chk("rst_instr", 32'(ifid_instr), 32'(0));
    @(negedge r_clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    gnt_en = 1'b0; rdy_en = 1'b1; redir_en = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = (memq.size() == 0) && (sb.size() == 0) && !ifid_valid;
    end
    chk("drain_complete", 32'(done), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[6];
    logic found;
    int exp_disc;
    n_pass = 0; n_total = 0; cyc = 0;
    popped_v = 1'b0; popped_pc = '0;

    tv[0] = '{gnt: 1, rdy: 1, req: 1, addr: 24'd0, valid: 0, pc: 24'd0};
    tv[1] = '{gnt: 1, rdy: 1, req: 1, addr: 24'd1, valid: 0, pc: 24'd0};
    tv[2] = '{gnt: 1, rdy: 1, req: 1, addr: 24'd2, valid: 1, pc: 24'd0};
    tv[3] = '{gnt: 1, rdy: 1, req: 1, addr: 24'd3, valid: 1, pc: 24'd1};
    tv[4] = '{gnt: 1, rdy: 1, req: 1, addr: 24'd4, valid: 1, pc: 24'd2};
    tv[5] = '{gnt: 1, rdy: 1, req: 1, addr: 24'd5, valid: 1, pc: 24'd3};

    // streaming fetch with a 1-cycle memory
    do_reset();
    for (int i = 0; i < 6; i++) begin
      gnt_en = tv[i].gnt; rdy_en = tv[i].rdy;
      drive();
      chk("tv_req", 32'(imem_req), 32'(tv[i].req));
      chk("tv_addr", 32'(imem_addr), 32'(tv[i].addr));
      chk("tv_valid", 32'(ifid_valid), 32'(tv[i].valid));
      if (tv[i].valid) chk("tv_pc", 32'(ifid_pc), 32'(tv[i].pc));
      sample();
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive();
      chk("no_bubble", 32'(ifid_valid), 32'(1));
      sample();
      advance();
    end
    drain();

    // ID back-pressure fills the window
    do_reset();
    gnt_en = 1'b1; rdy_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive();
      if (ifid_valid) begin
        chk("stall_head_pc", 32'(ifid_pc), 32'(0));
        chk("stall_head_instr", 32'(ifid_instr), 32'(instr_of(24'd0)));
      end
      sample();
      advance();
    end
    chk("stall_grants", 32'(n_grants), 32'(4));
    drive();
    chk("stall_req_low", 32'(imem_req), 32'(0));
    sample();
    advance();
    rdy_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive();
      if (i == 0) chk("resume_req_low", 32'(imem_req), 32'(0));
      if (i == 1) begin
        chk("resume_req", 32'(imem_req), 32'(1));
        chk("resume_addr", 32'(imem_addr), 32'(4));
      end
      sample();
      chk("resume_pop", 32'(popped_v), 32'(1));
      chk("resume_pop_pc", 32'(popped_pc), 32'(i));
      advance();
    end
    drain();

    // redirect with two stale requests in flight, 3-cycle memory
    do_reset();
    lat = 3; gnt_en = 1'b1; rdy_en = 1'b1;
    step(); step();
    gnt_en = 1'b0; redir_en = 1'b1; redir_tgt = 24'h000100;
    step();
    redir_en = 1'b0; gnt_en = 1'b1;
    drive();
    chk("redir_valid_low", 32'(ifid_valid), 32'(0));
    chk("redir_req", 32'(imem_req), 32'(1));
    chk("redir_addr", 32'(imem_addr), 32'(24'h000100));
    sample();
    advance();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(); sample();
      if (popped_v) begin
        found = 1'b1;
        chk("redir_first_pc", 32'(popped_pc), 32'(24'h000100));
      end
      advance();
    end
    chk("redir_first_seen", 32'(found), 32'(1));
    drain();

    // redirect coinciding with a response and an ID pop
    do_reset();
    lat = 3; gnt_en = 1'b1; rdy_en = 1'b1;
    found = 1'b0;
    exp_disc = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && ifid_valid) begin
        found = 1'b1;
        exp_disc = memq.size() - 1;
        redir_en = 1'b1; redir_tgt = 24'h000200;
      end
      step();
    end
    chk("coinc_seen", 32'(found), 32'(1));
    redir_en = 1'b0;
    drive();
    chk("coinc_valid_low", 32'(ifid_valid), 32'(0));
    chk("coinc_discard", 32'(dut.r_discard), 32'(exp_disc));
    sample();
    advance();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(); sample();
      if (popped_v) begin
        found = 1'b1;
        chk("coinc_first_pc", 32'(popped_pc), 32'(24'h000200));
      end
      advance();
    end
    chk("coinc_first_seen", 32'(found), 32'(1));
    drain();

    // PC wrap at the top of the address space
    do_reset();
    gnt_en = 1'b0; rdy_en = 1'b1; redir_en = 1'b1; redir_tgt = 24'hFFFFFF;
    step();
    redir_en = 1'b0; gnt_en = 1'b1;
    drive();
    chk("wrap_addr_top", 32'(imem_addr), 32'(24'hFFFFFF));
    sample(); advance();
    drive();
    chk("wrap_addr_zero", 32'(imem_addr), 32'(0));
    sample(); advance();
    exp_disc = 0;
    for (int i = 0; i < 20 && exp_disc < 2; i++) begin
      drive(); sample();
      if (popped_v) begin
        exp_disc++;
        if (exp_disc == 2) chk("wrap_pop_pc", 32'(popped_pc), 32'(0));
      end
      advance();
    end
    chk("wrap_pops", 32'(exp_disc), 32'(2));
    drain();

`ifdef DIAD_IAIF_PERF_EN
    begin
      logic [31:0] b0;
      gnt_en = 1'b0; rdy_en = 1'b1;
      drive();
      b0 = perf_bubble;
      sample(); advance();
      for (int i = 0; i < 4; i++) step();
      drive();
      chk("perf_bubble_delta", perf_bubble - b0, 32'd5);
      sample(); advance();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
